// File: rtl/cmp_seq_ctrl.sv
// cmp_seq_ctrl: MSB-first 2-bit digit magnitude-compare sequencer driving an RGB LED
// Define LED_PWM_EN to gate the LEDs with a free-running brightness PWM.
module cmp_seq_ctrl #(
  parameter int WIDTH    = 8,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    a_in,
  input  logic [WIDTH-1:0]    b_in,
  input  logic [PWM_BITS-1:0] bright,
  output logic                busy,
  output logic                done,
  output logic                red,
  output logic                green,
  output logic                blue
);
  localparam int ND = WIDTH / 2;
  localparam int IW = (ND > 1) ? $clog2(ND) : 1;
  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sa, sb;
  logic [IW-1:0]    idx_q, idx_d;
  logic [1:0]       da, db;
  logic             gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             red_f, green_f, blue_f;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    sa      = a_q >> (2 * idx_q);
    sb      = b_q >> (2 * idx_q);
    da      = sa[1:0];
    db      = sb[1:0];
    case (state_q)
      IDLE: if (start) begin
        a_d     = a_in;
        b_d     = b_in;
        idx_d   = IW'(ND - 1);
        state_d = COMPARE;
      end
      COMPARE: if (da != db) begin
        gt_d    = da > db;
        lt_d    = da < db;
        eq_d    = 1'b0;
        state_d = DONE;
      end else if (idx_q == '0) begin
        gt_d    = 1'b0;
        lt_d    = 1'b0;
        eq_d    = 1'b1;
        state_d = DONE;
      end else begin
        idx_d = idx_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d == COMPARE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign busy    = busy_q;
  assign done    = done_q;
  assign red_f   = gt_q | eq_q;
  assign green_f = lt_q | eq_q;
  assign blue_f  = gt_q | lt_q;
`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic                on;
  always_comb cnt_d = cnt_q + 1'b1;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign on    = cnt_q < bright;
  assign red   = red_f & on;
  assign green = green_f & on;
  assign blue  = blue_f & on;
`else
  logic unused_bright;
  assign unused_bright = ^bright;
  assign red   = red_f;
  assign green = green_f;
  assign blue  = blue_f;
`endif
endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// tb_cmp_seq_ctrl: directed checks of cmp_seq_ctrl handshake, latency and LED mapping
module tb_cmp_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a_in = '0, b_in = '0;
  logic [3:0] bright = 4'd15;
  logic       busy, done, red, green, blue;
  int         total = 0, bad = 0;

  cmp_seq_ctrl #(.WIDTH(8), .PWM_BITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .bright(bright),
    .busy(busy), .done(done), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic run_cmp(input logic [7:0] a, input logic [7:0] b, input int n,
                         input logic er, input logic eg, input logic eb);
    @(negedge clk);
    a_in = a; b_in = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_k", busy, 1'b1);
    chk("nodone_k", done, 1'b0);
    for (int i = 1; i < n; i++) begin
      @(posedge clk); #1;
      chk("busy_mid", busy, 1'b1);
      chk("nodone_mid", done, 1'b0);
    end
    @(posedge clk); #1;
    chk("done_kn", done, 1'b1);
    chk("busy_kn", busy, 1'b0);
`ifndef LED_PWM_EN
    chk("red", red, er);
    chk("green", green, eg);
    chk("blue", blue, eb);
`endif
    @(posedge clk); #1;
    chk("done_pulse", done, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_red", red, 1'b0);
    chk("rst_green", green, 1'b0);
    chk("rst_blue", blue, 1'b0);
    rst = 1'b0;

    run_cmp(8'hA5, 8'hA5, 4, 1'b1, 1'b1, 1'b0);
    run_cmp(8'hC0, 8'h40, 1, 1'b1, 1'b0, 1'b1);
    run_cmp(8'h12, 8'h13, 4, 1'b0, 1'b1, 1'b1);

    // second start lands on the edge that enters DONE and must be dropped
    @(negedge clk);
    a_in = 8'h00; b_in = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    a_in = 8'hFF; b_in = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign_done", done, 1'b1);
`ifndef LED_PWM_EN
    chk("ign_green", green, 1'b1);
    chk("ign_red", red, 1'b0);
`endif
    @(posedge clk); #1;
    chk("ign_idle_busy", busy, 1'b0);
    chk("ign_idle_done", done, 1'b0);
    @(posedge clk); #1;
    chk("ign_still_idle", busy, 1'b0);

    // reset during COMPARE
    @(negedge clk);
    a_in = 8'hA5; b_in = 8'hA5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_red", red, 1'b0);
    chk("abort_green", green, 1'b0);
    chk("abort_blue", blue, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort_nodone", done, 1'b0);
    end

`ifdef LED_PWM_EN
    bright = 4'd4;
    run_cmp(8'hC0, 8'h40, 1, 1'b1, 1'b0, 1'b1);
    begin
      int hi = 0, gr = 0;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        hi += int'(red);
        gr += int'(green);
      end
      total++;
      assert (hi == 4) else begin
        bad++;
        $error("FAIL pwm_red_duty observed=%0d expected=4", hi);
      end
      total++;
      assert (gr == 0) else begin
        bad++;
        $error("FAIL pwm_green_off observed=%0d expected=0", gr);
      end
    end
`else
    bright = 4'd0;
    @(posedge clk); #1;
    chk("static_led_red", red, 1'b0);
    run_cmp(8'hC0, 8'h40, 1, 1'b1, 1'b0, 1'b1);
    chk("static_led_hold", red, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
